card_dealer: RTL and testbench

Deck-management stage feeding the card renderer's `card_symbol` / `card_number` inputs. It holds a 52-card deck, draws a pseudo-random undealt card on each request, and never repeats a card until a new game starts. Game control logic issues deal requests. Each dealt card is registered and held stable for the renderer until the next deal.

---
 rtl/card_dealer_if.sv | 24 ++
 rtl/card_dealer.sv | 117 +++++++++++
 tb/tb_card_dealer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// Deal-request and card-output bundle between game control and the dealer.
interface card_dealer_if;
    logic       new_game;
    logic       deal_req;
    logic [1:0] card_symbol;
    logic [3:0] card_number;
    logic       card_valid;
    logic       busy;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       deal_err;

    modport master (
        output new_game, deal_req,
        input  card_symbol, card_number, card_valid,
        input  busy, cards_left, deck_empty, deal_err
    );

    modport slave (
        input  new_game, deal_req,
        output card_symbol, card_number, card_valid,
        output busy, cards_left, deck_empty, deal_err
    );
endinterface

// File: rtl/card_dealer.sv
// 52-card deck: LFSR-seeded draw with linear probing over a used mask.
module card_dealer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    card_dealer_if.slave bus
);
    typedef enum logic {IDLE, PROBE} state_t;

    state_t      state, state_next;
    logic [15:0] lfsr, lfsr_next;
    logic [5:0]  idx, idx_seed, idx_inc;
    logic [51:0] used;
    logic [5:0]  cards_left;
    logic [1:0]  sym, dec_sym;
    logic [3:0]  num, dec_num;
    logic        card_valid, deal_err;
    logic        take, hit, reject;

    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign idx_seed  = (lfsr[5:0] >= 6'd52) ? lfsr[5:0] - 6'd52 : lfsr[5:0];
    assign idx_inc   = (idx == 6'd51) ? 6'd0 : idx + 6'd1;

    // Rank is taken modulo 16 on idx[3:0]; result always lands in 1..13.
    always_comb begin
        dec_sym = 2'd3;
        dec_num = idx[3:0] - 4'd6;
        if (idx < 6'd13) begin
            dec_sym = 2'd0;
            dec_num = idx[3:0] + 4'd1;
        end else if (idx < 6'd26) begin
            dec_sym = 2'd1;
            dec_num = idx[3:0] - 4'd12;
        end else if (idx < 6'd39) begin
            dec_sym = 2'd2;
            dec_num = idx[3:0] - 4'd9;
        end
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        hit        = 1'b0;
        reject     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.deal_req) begin
                    if (cards_left != 6'd0) begin
                        take       = 1'b1;
                        state_next = PROBE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            PROBE: begin
                if (!used[idx]) begin
                    hit        = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
        if (bus.new_game) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lfsr  <= LFSR_SEED;
        end else begin
            state <= state_next;
            lfsr  <= lfsr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= 6'd0;
            used       <= '0;
            cards_left <= 6'd52;
            sym        <= 2'd0;
            num        <= 4'd0;
            card_valid <= 1'b0;
            deal_err   <= 1'b0;
        end else begin
            card_valid <= 1'b0;
            deal_err   <= 1'b0;
            if (bus.new_game) begin
                used       <= '0;
                cards_left <= 6'd52;
                sym        <= 2'd0;
                num        <= 4'd0;
            end else begin
                if (take)   idx      <= idx_seed;
                if (reject) deal_err <= 1'b1;
                if (hit) begin
                    used[idx]  <= 1'b1;
                    sym        <= dec_sym;
                    num        <= dec_num;
                    card_valid <= 1'b1;
                    cards_left <= cards_left - 6'd1;
                end else if (state == PROBE) begin
                    idx <= idx_inc;
                end
            end
        end
    end

    assign bus.card_symbol = sym;
    assign bus.card_number = num;
    assign bus.card_valid  = card_valid;
    assign bus.busy        = (state == PROBE);
    assign bus.cards_left  = cards_left;
    assign bus.deck_empty  = (cards_left == 6'd0);
    assign bus.deal_err    = deal_err;
endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer with an LFSR/deck reference model.
module tb_card_dealer;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    card_dealer_if bus();

    card_dealer #(.LFSR_SEED(SEED)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int idx;
        int lat;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          passes = 0;
    int          m_left = 52;
    logic [15:0] m_lfsr;
    logic [51:0] m_used = '0;
    logic [51:0] seen = '0;

    // Reference LFSR: runs every cycle, reloaded only by rst.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else if (m_lfsr[0]) m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
        else m_lfsr <= m_lfsr >> 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_deal();
        exp_t e;
        int i;
        int p;
        i = int'(m_lfsr[5:0]);
        if (i >= 52) i -= 52;
        p = 0;
        while (m_used[i] && p < 52) begin
            i = (i == 51) ? 0 : i + 1;
            p++;
        end
        e.idx = i;
        e.lat = p + 1;
        sbq.push_back(e);
        m_used[i] = 1'b1;
        bus.deal_req = 1'b1;
        tick();
        bus.deal_req = 1'b0;
    endtask

    task automatic await_card(input string tag, input int start,
                              output int got);
        exp_t e;
        int n;
        n = start;
        got = -1;
        while (!bus.card_valid && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, bus.card_valid, 1);
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sbq.pop_front();
            m_left--;
            got = int'(bus.card_symbol) * 13 + int'(bus.card_number) - 1;
            check({tag, "_lat"}, n, e.lat);
            check({tag, "_card"}, got, e.idx);
            check({tag, "_left"}, bus.cards_left, m_left);
            check({tag, "_busy"}, bus.busy, 0);
            check({tag, "_rank"},
                  (bus.card_number >= 1 && bus.card_number <= 13), 1);
            if (got >= 0 && got < 52) begin
                check({tag, "_distinct"}, seen[got], 0);
                seen[got] = 1'b1;
            end
        end
        tick();
        check({tag, "_pulse"}, bus.card_valid, 0);
    endtask

    task automatic clear_model();
        m_used = '0;
        seen = '0;
        m_left = 52;
        sbq.delete();
    endtask

    initial begin
        int got;
        int first;
        int nvalid;
        logic [3:0] held;

        bus.new_game = 1'b0;
        bus.deal_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_left", bus.cards_left, 52);
        check("rst_num", bus.card_number, 0);
        check("rst_sym", bus.card_symbol, 0);
        check("rst_valid", bus.card_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_empty", bus.deck_empty, 0);
        check("rst_err", bus.deal_err, 0);

        // Full deck; the first deal doubles as the single-deal case
        issue_deal();
        await_card("deal1", 0, first);
        for (int k = 2; k <= 52; k++) begin
            issue_deal();
            await_card("deal", 0, got);
        end
        check("deck_seen_all", (seen == {52{1'b1}}), 1);
        check("deck_empty", bus.deck_empty, 1);
        check("deck_left0", bus.cards_left, 0);

        held = bus.card_number;
        bus.deal_req = 1'b1;
        tick();
        bus.deal_req = 1'b0;
        check("err_pulse", bus.deal_err, 1);
        check("err_novalid", bus.card_valid, 0);
        check("err_busy", bus.busy, 0);
        tick();
        check("err_clear", bus.deal_err, 0);
        check("err_left", bus.cards_left, 0);
        check("hold_num", bus.card_number, held);

        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        clear_model();
        check("ng_left", bus.cards_left, 52);
        check("ng_num", bus.card_number, 0);
        check("ng_empty", bus.deck_empty, 0);

        // Second request while busy is dropped
        issue_deal();
        check("busy_high", bus.busy, 1);
        bus.deal_req = 1'b1;
        tick();
        bus.deal_req = 1'b0;
        await_card("busyreq", 1, got);
        nvalid = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (bus.card_valid) nvalid++;
        end
        check("busyreq_extra", nvalid, 0);
        check("busyreq_left", bus.cards_left, 51);

        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        clear_model();

        // new_game aborting an in-flight deal
        issue_deal();
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        clear_model();
        check("abort_valid", bus.card_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_left", bus.cards_left, 52);
        check("abort_num", bus.card_number, 0);
        nvalid = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.card_valid) nvalid++;
        end
        check("abort_none", nvalid, 0);

        bus.new_game = 1'b1;
        bus.deal_req = 1'b1;
        tick();
        bus.new_game = 1'b0;
        bus.deal_req = 1'b0;
        check("ngreq_busy", bus.busy, 0);
        nvalid = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.card_valid) nvalid++;
        end
        check("ngreq_none", nvalid, 0);
        check("ngreq_left", bus.cards_left, 52);

        // Asynchronous reset in the middle of a deal
        issue_deal();
        await_card("pre_rst", 0, got);
        issue_deal();
        check("pre_rst_busy", bus.busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        clear_model();
        check("arst_busy", bus.busy, 0);
        check("arst_left", bus.cards_left, 52);
        check("arst_num", bus.card_number, 0);
        check("arst_sym", bus.card_symbol, 0);
        check("arst_valid", bus.card_valid, 0);
        check("arst_empty", bus.deck_empty, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        issue_deal();
        await_card("post_rst", 0, got);
        check("restart_same_card", got, first);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
